column_init_gen: RTL and testbench
==================================

# column_init_gen

Parametrised initial-condition generator for the drum/string wave-equation simulation. It replaces the fixed 33-row combinational LUT with a sequential engine. On `start`, it streams a triangular (1D) or pyramidal (2D) displacement profile, one node per beat, over a valid/ready handshake into the column memories. Peak position and slope are runtime-programmable. The engine emits identical u_n and u_nm1, giving zero initial velocity.

## Interface
- DATA_W, 18: signed sample width.
- FRAC_W, 17: fractional bits (documentation only; arithmetic is integer on raw words).
- NUM_ROWS, 33: nodes per column.
- ROW_W, 6: row index width; must hold NUM_ROWS-1.
- NUM_COLS, 1: number of columns.
- COL_W, 5: column index width; must hold NUM_COLS-1 (min 1).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; ignored unless idle.
- mode  in  1  0 = 1D row triangle, 1 = 2D pyramid (min of row and column profiles).
- peak_row  in  ROW_W  row at which row profile stops rising.
- peak_col  in  COL_W  column at which column profile stops rising.
- step  in  DATA_W  unsigned slope increment per node (MSB must be 0).
- busy  out  1  high from accepted start until done.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts beat.
- out_row  out  ROW_W  row index of beat.
- out_col  out  COL_W  column index of beat.
- out_u_n  out  DATA_W  signed displacement, time n.
- out_u_nm1  out  DATA_W  signed displacement, time n-1 (equal to out_u_n).
- out_last  out  1  high on final beat (row NUM_ROWS-1, col NUM_COLS-1).
- done  out  1  one-cycle pulse after final beat accepted.

## Operation
- FSM states: IDLE, RUN, FIN.
  - IDLE → RUN on start. Capture mode, peak_row, peak_col and step; clear both indices and accumulators.
  - RUN → FIN on transfer (out_valid & out_ready) with out_last.
  - FIN → IDLE unconditionally; done=1 in FIN.
- Scan order: column outer, row inner (col 0 rows 0..NUM_ROWS-1, then col 1, ...).
- Row accumulator r is 0 at row 0. On each row advance from row i:
  - i < peak_row: r += step, saturating at 2^(DATA_W-1)-1.
  - Otherwise: r -= step, saturating at 0.
  - r resets to 0 at each column change.
- Column accumulator c follows the same rule per column advance, using peak_col.
- Edge nodes are fixed boundary. Output is 0 at row 0 and row NUM_ROWS-1. In mode 1 it is also 0 at col 0 and col NUM_COLS-1.
- Interior value:
  - mode 0: r.
  - mode 1: min(r, c).
- If mode=1 and NUM_COLS<3, the block behaves as mode 0.
- peak_row ≥ NUM_ROWS-1 gives a monotone rising profile (still zeroed at the last row).
- Changes on step, peak_row, peak_col or mode during RUN are ignored.
- start during RUN or FIN is ignored; no queuing.

## Timing
- Reset values: busy=0, out_valid=0, out_last=0, done=0, out_row=0, out_col=0, out_u_n=0, out_u_nm1=0; FSM=IDLE.
- Start accepted at edge k: busy=1 and out_valid=1 from cycle k+1, presenting row 0 col 0.
- Throughput is one beat per cycle while out_ready=1.
- All beat outputs hold stable while out_valid & !out_ready.
- out_valid stays high throughout RUN; it is never withdrawn before transfer.
- Last beat transferred at edge m: in cycle m+1, out_valid=0, done=1 and busy=0.
- Total beats = NUM_ROWS*NUM_COLS. Minimum start-to-done is NUM_ROWS*NUM_COLS+1 cycles.
- rst asserted mid-run immediately forces reset values. No done pulse is issued. A new start is accepted on the first edge after release.
- Outputs are registered; no combinational path from out_ready or start to outputs.

## Test plan
- Default params, mode=0, peak_row=16, step=18'h00400, out_ready=1:
  - Expect 33 beats on consecutive cycles.
  - row 8 = 18'h02000, row 16 = 18'h04000, row 17 = 18'h03C00, row 31 = 18'h00400, rows 0/32 = 0.
  - u_nm1==u_n on every beat; out_last on row 32; done one cycle later.
- Same run with out_ready toggling pseudo-randomly:
  - Identical 33-value sequence.
  - Beats stable while stalled; done only after the 33rd transfer.
- step=18'h0FFFF, peak_row=16:
  - Rising rows saturate at 18'h1FFFF.
  - Falling rows saturate at 0, never going negative.
- NUM_ROWS=5, NUM_COLS=5, mode=1, peak_row=2, peak_col=2, step=18'h00400:
  - (2,2)=18'h00800, (1,2)=18'h00400, (1,1)=18'h00400.
  - All edge nodes 0; 25 beats, column-major order.
- start re-pulsed at beat 10:
  - Ignored; the sequence is unchanged.
- rst pulsed at beat 10, then new start:
  - All outputs 0 during reset; no done.
  - The new run restarts cleanly at row 0 col 0 with the full sequence.

Source files
------------

// File: rtl/column_init_gen_if.sv
// Beat stream from the initial-condition generator into the column memories.
// The master holds every beat field stable until out_ready is seen with out_valid.
interface column_init_gen_if #(
  parameter int DATA_W = 18,
  parameter int ROW_W  = 6,
  parameter int COL_W  = 5
);
  logic                     out_valid;
  logic                     out_ready;
  logic [ROW_W-1:0]         out_row;
  logic [COL_W-1:0]         out_col;
  logic signed [DATA_W-1:0] out_u_n;
  logic signed [DATA_W-1:0] out_u_nm1;
  logic                     out_last;

  modport master (
    output out_valid, out_row, out_col, out_u_n, out_u_nm1, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_row, out_col, out_u_n, out_u_nm1, out_last,
    output out_ready
  );
endinterface

// File: rtl/column_init_gen.sv
// Streams a triangular (1D) or pyramidal (2D) initial displacement, one node per beat,
// first beat the cycle after start; all beat outputs are registered and hold while stalled.
module column_init_gen #(
  parameter int DATA_W   = 18,
  parameter int FRAC_W   = 17,
  parameter int NUM_ROWS = 33,
  parameter int ROW_W    = 6,
  parameter int NUM_COLS = 1,
  parameter int COL_W    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                mode_i,
  input  logic [ROW_W-1:0]    peak_row_i,
  input  logic [COL_W-1:0]    peak_col_i,
  input  logic [DATA_W-1:0]   step_i,
  output logic                busy_o,
  output logic                done_o,
  column_init_gen_if.master   out_if
);

  if (FRAC_W >= DATA_W || NUM_ROWS < 2 || NUM_COLS < 1 ||
      (NUM_ROWS - 1) >= (1 << ROW_W) || (NUM_COLS - 1) >= (1 << COL_W)) begin : g_param_check
    $error("column_init_gen: illegal parameter combination");
  end

  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam bit                USE_2D   = (NUM_COLS >= 3);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t              state_q;
  logic                mode_q;
  logic [ROW_W-1:0]    peak_row_q;
  logic [COL_W-1:0]    peak_col_q;
  logic [DATA_W-1:0]   step_q;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [DATA_W-1:0]   r_q, r_d;
  logic [DATA_W-1:0]   c_q, c_d;
  logic [DATA_W-1:0]   u_q, u_d;
  logic                last_q, last_d;
  logic                vld_q;
  logic                busy_q;
  logic                done_q;
  logic                row_wrap;
  logic                xfer;

  function automatic logic [DATA_W-1:0] sat_step(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] stp,
                                                 input logic              up);
    logic [DATA_W:0] sum;
    sum = {1'b0, acc} + {1'b0, stp};
    if (up) begin
      return (sum > {1'b0, SAT_MAX}) ? SAT_MAX : sum[DATA_W-1:0];
    end
    return (acc < stp) ? '0 : acc - stp;
  endfunction

  // Boundary nodes are pinned to zero; the 2D profile is the lower of the two ramps.
  function automatic logic [DATA_W-1:0] node_val(input logic [ROW_W-1:0]  row,
                                                 input logic [COL_W-1:0]  col,
                                                 input logic [DATA_W-1:0] r,
                                                 input logic [DATA_W-1:0] c,
                                                 input logic              two_d);
    if (row == '0 || row == LAST_ROW) return '0;
    if (two_d && (col == '0 || col == LAST_COL)) return '0;
    if (two_d && (c < r)) return c;
    return r;
  endfunction

  // Everything for the following beat is precomputed so outputs update straight from flops.
  always_comb begin
    row_wrap = (row_q == LAST_ROW);
    row_d    = row_wrap ? '0 : row_q + ROW_W'(1);
    col_d    = row_wrap ? col_q + COL_W'(1) : col_q;
    r_d      = row_wrap ? '0 : sat_step(r_q, step_q, row_q < peak_row_q);
    c_d      = row_wrap ? sat_step(c_q, step_q, col_q < peak_col_q) : c_q;
    u_d      = node_val(row_d, col_d, r_d, c_d, mode_q);
    last_d   = (row_d == LAST_ROW) && (col_d == LAST_COL);
  end

  assign xfer = vld_q & out_if.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      peak_row_q <= '0;
      peak_col_q <= '0;
      step_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      r_q        <= '0;
      c_q        <= '0;
      u_q        <= '0;
      last_q     <= 1'b0;
      vld_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q    <= RUN;
            mode_q     <= mode_i & USE_2D;
            peak_row_q <= peak_row_i;
            peak_col_q <= peak_col_i;
            step_q     <= step_i;
            row_q      <= '0;
            col_q      <= '0;
            r_q        <= '0;
            c_q        <= '0;
            u_q        <= '0;
            last_q     <= 1'b0;
            vld_q      <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          if (xfer) begin
            if (last_q) begin
              state_q <= FIN;
              vld_q   <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              row_q  <= row_d;
              col_q  <= col_d;
              r_q    <= r_d;
              c_q    <= c_d;
              u_q    <= u_d;
              last_q <= last_d;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign out_if.out_valid = vld_q;
  assign out_if.out_row   = row_q;
  assign out_if.out_col   = col_q;
  assign out_if.out_u_n   = u_q;
  assign out_if.out_u_nm1 = u_q;
  assign out_if.out_last  = last_q;

endmodule

// File: tb/tb_column_init_gen.sv
// Scoreboard bench: stimulus queues expected beats, per-DUT monitors pop and compare on transfer.
module tb_column_init_gen;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0]  row;
    logic [4:0]  col;
    logic [17:0] u;
    logic        last;
  } beat_t;

  beat_t exp_a[$];
  beat_t exp_b[$];

  column_init_gen_if #(.DATA_W(18), .ROW_W(6), .COL_W(5)) if_a ();
  column_init_gen_if #(.DATA_W(18), .ROW_W(6), .COL_W(5)) if_b ();

  logic        start_a, mode_a, busy_a, done_a;
  logic [5:0]  prow_a;
  logic [4:0]  pcol_a;
  logic [17:0] step_a;
  logic        start_b, mode_b, busy_b, done_b;
  logic [5:0]  prow_b;
  logic [4:0]  pcol_b;
  logic [17:0] step_b;

  column_init_gen #(.DATA_W(18), .FRAC_W(17), .NUM_ROWS(33), .ROW_W(6), .NUM_COLS(1), .COL_W(5)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .mode_i(mode_a), .peak_row_i(prow_a),
    .peak_col_i(pcol_a), .step_i(step_a), .busy_o(busy_a), .done_o(done_a), .out_if(if_a)
  );

  column_init_gen #(.DATA_W(18), .FRAC_W(17), .NUM_ROWS(5), .ROW_W(6), .NUM_COLS(5), .COL_W(5)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .mode_i(mode_b), .peak_row_i(prow_b),
    .peak_col_i(pcol_b), .step_i(step_b), .busy_o(busy_b), .done_o(done_b), .out_if(if_b)
  );

  assign if_b.out_ready = 1'b1;

  logic rand_rdy = 1'b0;
  always @(posedge clk) begin
    #1;
    if_a.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Closed-form ramp: clamped rise up to the peak, then linear fall clamped at zero.
  function automatic logic [17:0] prof(input int i, input int peak, input int stp);
    longint mx;
    longint v;
    longint vp;
    mx = 131071;
    if (i <= peak) begin
      v = longint'(i) * stp;
      return (v > mx) ? 18'(mx) : 18'(v);
    end
    vp = longint'(peak) * stp;
    if (vp > mx) vp = mx;
    v = vp - longint'(i - peak) * stp;
    if (v < 0) v = 0;
    return 18'(v);
  endfunction

  task automatic push_a(input int peak, input int stp);
    beat_t b;
    for (int i = 0; i < 33; i++) begin
      b.row  = 6'(i);
      b.col  = 5'd0;
      b.u    = (i == 0 || i == 32) ? 18'd0 : prof(i, peak, stp);
      b.last = (i == 32);
      exp_a.push_back(b);
    end
  endtask

  task automatic push_b(input int pr, input int pc, input int stp);
    beat_t b;
    logic [17:0] rv, cv;
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < 5; r++) begin
        rv     = prof(r, pr, stp);
        cv     = prof(c, pc, stp);
        b.row  = 6'(r);
        b.col  = 5'(c);
        b.u    = (r == 0 || r == 4 || c == 0 || c == 4) ? 18'd0 : ((rv < cv) ? rv : cv);
        b.last = (r == 4 && c == 4);
        exp_b.push_back(b);
      end
    end
  endtask

  int run_tag = 0;
  int beats_a = 0;
  logic stall_a = 1'b0, pend_a = 1'b0, stall_b = 1'b0, pend_b = 1'b0;
  logic [47:0] held_a, held_b;

  task automatic spot_a(input beat_t g);
    if (run_tag == 1 || run_tag == 2) begin
      case (g.row)
        6'd8:  check("a.row8", g.u, 18'h02000);
        6'd16: check("a.row16", g.u, 18'h04000);
        6'd17: check("a.row17", g.u, 18'h03C00);
        6'd31: check("a.row31", g.u, 18'h00400);
        6'd32: check("a.row32", g.u, 18'h00000);
        default: ;
      endcase
    end else if (run_tag == 3) begin
      case (g.row)
        6'd3:  check("sat.row3", g.u, 18'h1FFFF);
        6'd16: check("sat.row16", g.u, 18'h1FFFF);
        6'd17: check("sat.row17", g.u, 18'h10000);
        6'd18: check("sat.row18", g.u, 18'h00001);
        6'd19: check("sat.row19", g.u, 18'h00000);
        6'd31: check("sat.row31", g.u, 18'h00000);
        default: ;
      endcase
    end
  endtask

  task automatic spot_b(input beat_t g);
    case ({g.row[2:0], g.col[2:0]})
      {3'd2, 3'd2}: check("b.r2c2", g.u, 18'h00800);
      {3'd1, 3'd2}: check("b.r1c2", g.u, 18'h00400);
      {3'd1, 3'd1}: check("b.r1c1", g.u, 18'h00400);
      {3'd2, 3'd1}: check("b.r2c1", g.u, 18'h00400);
      default: ;
    endcase
  endtask

  task automatic cmp_beat(input string tag, input beat_t g, input logic [17:0] unm1, input beat_t e);
    check({tag, ".row"}, g.row, e.row);
    check({tag, ".col"}, g.col, e.col);
    check({tag, ".u_n"}, g.u, e.u);
    check({tag, ".u_nm1"}, unm1, e.u);
    check({tag, ".last"}, g.last, e.last);
  endtask

  always @(negedge clk) begin : mon_a
    beat_t g;
    beat_t e;
    g = {if_a.out_row, if_a.out_col, if_a.out_u_n, if_a.out_last};
    if (rst) begin
      stall_a = 1'b0;
      pend_a  = 1'b0;
    end else begin
      if (stall_a) check("a.hold", {g, if_a.out_u_nm1}, held_a);
      if (done_a || pend_a) check("a.done", done_a, pend_a);
      if (pend_a) check("a.busy_done", {busy_a, if_a.out_valid}, 2'b00);
      pend_a = 1'b0;
      if (if_a.out_valid && if_a.out_ready) begin
        beats_a++;
        if (exp_a.size() == 0) begin
          check("a.unexpected_beat", 1, 0);
        end else begin
          e = exp_a.pop_front();
          cmp_beat("a", g, if_a.out_u_nm1, e);
          spot_a(g);
        end
        pend_a = g.last;
      end
      stall_a = if_a.out_valid && !if_a.out_ready;
      held_a  = {g, if_a.out_u_nm1};
    end
  end

  always @(negedge clk) begin : mon_b
    beat_t g;
    beat_t e;
    g = {if_b.out_row, if_b.out_col, if_b.out_u_n, if_b.out_last};
    if (rst) begin
      stall_b = 1'b0;
      pend_b  = 1'b0;
    end else begin
      if (stall_b) check("b.hold", {g, if_b.out_u_nm1}, held_b);
      if (done_b || pend_b) check("b.done", done_b, pend_b);
      pend_b = 1'b0;
      if (if_b.out_valid && if_b.out_ready) begin
        if (exp_b.size() == 0) begin
          check("b.unexpected_beat", 1, 0);
        end else begin
          e = exp_b.pop_front();
          cmp_beat("b", g, if_b.out_u_nm1, e);
          spot_b(g);
        end
        pend_b = g.last;
      end
      stall_b = if_b.out_valid && !if_b.out_ready;
      held_b  = {g, if_b.out_u_nm1};
    end
  end

  task automatic go_a(input logic m, input int pr, input int pc, input int stp);
    @(posedge clk);
    #1;
    mode_a = m; prow_a = 6'(pr); pcol_a = 5'(pc); step_a = 18'(stp); start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
  endtask

  task automatic go_b(input logic m, input int pr, input int pc, input int stp);
    @(posedge clk);
    #1;
    mode_b = m; prow_b = 6'(pr); pcol_b = 5'(pc); step_b = 18'(stp); start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".left_a"}, exp_a.size(), 0);
    check({tag, ".left_b"}, exp_b.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_beats_a(input int cnt, input int budget);
    int b0;
    int n;
    b0 = beats_a;
    n  = 0;
    while (beats_a - b0 < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("a.beat_wait", (beats_a - b0 >= cnt), 1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    logic saw_done;
    rst = 1'b1;
    start_a = 1'b0; mode_a = 1'b0; prow_a = '0; pcol_a = '0; step_a = '0;
    start_b = 1'b0; mode_b = 1'b0; prow_b = '0; pcol_b = '0; step_b = '0;
    repeat (2) @(negedge clk);
    check("rst.valid", if_a.out_valid, 0);
    check("rst.busy", busy_a, 0);
    check("rst.done", done_a, 0);
    check("rst.last", if_a.out_last, 0);
    check("rst.row_col", {if_a.out_row, if_a.out_col}, 0);
    check("rst.u", {if_a.out_u_n, if_a.out_u_nm1}, 0);
    check("rst.b_valid_busy", {if_b.out_valid, busy_b}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1D triangle, full throughput, cycle-exact start-to-done.
    run_tag = 1;
    push_a(16, 'h400);
    go_a(1'b0, 16, 0, 'h400);
    @(negedge clk);
    check("a.first_vld_busy", {if_a.out_valid, busy_a}, 2'b11);
    check("a.first_row", if_a.out_row, 0);
    n = 1;
    while (!done_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("a.start_to_done", n, 34);
    drain("run1", 200);

    // Same profile under random backpressure.
    run_tag = 2;
    rand_rdy = 1'b1;
    push_a(16, 'h400);
    go_a(1'b0, 16, 0, 'h400);
    drain("run2", 3000);
    rand_rdy = 1'b0;

    // Saturation both ways.
    run_tag = 3;
    push_a(16, 'h0FFFF);
    go_a(1'b0, 16, 0, 'h0FFFF);
    drain("sat", 200);

    // 5x5 pyramid.
    run_tag = 0;
    push_b(2, 2, 'h400);
    go_b(1'b1, 2, 2, 'h400);
    drain("pyr", 200);

    // start re-pulsed mid-run must not disturb the stream.
    run_tag = 1;
    push_a(16, 'h400);
    go_a(1'b0, 16, 0, 'h400);
    wait_beats_a(10, 200);
    @(posedge clk);
    #1;
    mode_a = 1'b1; prow_a = 6'd3; step_a = 18'h01000; start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    drain("repulse", 200);

    // Reset mid-run, then restart on the first edge after release.
    push_a(16, 'h400);
    go_a(1'b0, 16, 0, 'h400);
    wait_beats_a(10, 200);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_a.delete();
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done = saw_done | done_a;
    end
    check("rst_mid.no_done", saw_done, 0);
    check("rst_mid.vld_busy_last", {if_a.out_valid, busy_a, if_a.out_last}, 0);
    check("rst_mid.row_col", {if_a.out_row, if_a.out_col}, 0);
    check("rst_mid.u", {if_a.out_u_n, if_a.out_u_nm1}, 0);
    push_a(16, 'h400);
    @(posedge clk);
    #1;
    rst = 1'b0; mode_a = 1'b0; prow_a = 6'd16; step_a = 18'h00400; start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    @(negedge clk);
    check("restart.vld_row", {if_a.out_valid, if_a.out_row, if_a.out_col}, {1'b1, 6'd0, 5'd0});
    drain("restart", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
